// File: rtl/corexy_pkg.sv
// Shared types for the CoreXY move sequencer: FSM states, the queued move word
// and the zero-period guard applied to speed words.
package corexy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_RISE,
        WAIT_FALL,
        GAP
    } seq_state_t;

    typedef struct packed {
        logic [31:0] step_1;
        logic [31:0] speed_1;
        logic [31:0] step_2;
        logic [31:0] speed_2;
    } move_t;

    localparam int STEP_DIR_BIT = 31;

    // A zero half-period would stall the core, so it is promoted to 1.
    function automatic logic [31:0] fix_speed(input logic [31:0] s);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO with a level output and a synchronous clear that
// overrides any push or pop in the same cycle.
module move_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             empty, push, pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign push    = wr_en & ~full & ~clr;
    assign pop     = rd_en & ~empty & ~clr;
    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/corexy_move_sequencer.sv
// Feeds queued CoreXY move segments to the stepper core one at a time,
// counting completed moves and halting dispatch after an endstop-terminated move.
module corexy_move_sequencer
    import corexy_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int GAP   = 4,
    parameter int WAIT  = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [31:0]   wr_step_1,
    input  logic [31:0]   wr_speed_1,
    input  logic [31:0]   wr_step_2,
    input  logic [31:0]   wr_speed_2,
    input  logic          run,
    input  logic          flush,
    input  logic          endstop_hit,
    input  logic          steppers_driving,
    output logic [31:0]   stepper_step_in_1,
    output logic [31:0]   stepper_step_in_2,
    output logic [31:0]   stepper_speed_1,
    output logic [31:0]   stepper_speed_2,
    output logic          start_driving,
    output logic [AW:0]   level,
    output logic [15:0]   done_count,
    output logic          busy,
    output logic          halted
);

    localparam int CMAX = (WAIT > GAP) ? WAIT : GAP;
    localparam int CW   = $clog2(CMAX + 1);

    seq_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit_q, hit_d;
    logic          halted_q, halted_d;
    logic [15:0]   done_q, done_d;
    move_t         out_q, out_d;
    move_t         wr_move, head;
    logic          full, pop;

    always_comb begin
        wr_move.step_1  = wr_step_1;
        wr_move.speed_1 = fix_speed(wr_speed_1);
        wr_move.step_2  = wr_step_2;
        wr_move.speed_2 = fix_speed(wr_speed_2);
    end

    move_fifo #(.WIDTH($bits(move_t)), .DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .wr_en   (wr_valid),
        .wr_data (wr_move),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .level   (level)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hit_d         = hit_q;
        halted_d      = halted_q;
        done_d        = done_q;
        out_d         = out_q;
        pop           = 1'b0;
        start_driving = 1'b0;
        case (state_q)
            IDLE: begin
                // A flush in the same cycle empties the queue, so no dispatch.
                if (run && (level != '0) && !halted_q && !flush) state_d = LOAD;
            end
            LOAD: begin
                pop     = 1'b1;
                out_d   = head;
                state_d = START;
            end
            START: begin
                start_driving = 1'b1;
                cnt_d         = '0;
                hit_d         = 1'b0;
                state_d       = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (steppers_driving) begin
                    state_d = WAIT_FALL;
                end else if (cnt_q == CW'(WAIT - 1)) begin
                    done_d  = done_q + 16'd1;
                    cnt_d   = '0;
                    state_d = corexy_pkg::GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_FALL: begin
                hit_d = hit_q | endstop_hit;
                if (!steppers_driving) begin
                    done_d = done_q + 16'd1;
                    if (hit_q | endstop_hit) begin
                        halted_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = corexy_pkg::GAP;
                    end
                end
            end
            corexy_pkg::GAP: begin
                if (cnt_q == CW'(GAP - 1)) state_d = IDLE;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (flush) halted_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hit_q    <= 1'b0;
            halted_q <= 1'b0;
            done_q   <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hit_q    <= hit_d;
            halted_q <= halted_d;
            done_q   <= done_d;
            out_q    <= out_d;
        end
    end

    assign wr_ready          = ~full;
    assign busy              = (state_q != IDLE);
    assign halted            = halted_q;
    assign done_count        = done_q;
    assign stepper_step_in_1 = out_q.step_1;
    assign stepper_speed_1   = out_q.speed_1;
    assign stepper_step_in_2 = out_q.step_2;
    assign stepper_speed_2   = out_q.speed_2;

endmodule
